dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder side of the CPU data-memory interface: a multi-cycle data memory that serves
//  load/store requests issued by the MEM stage.
//  Accepts a request and holds the pipeline via stall_o for LATENCY cycles.
//  Then commits the write or returns read data with a one-cycle ack_o pulse.
//  Replaces the single-cycle data memory where slower memory timing must be modelled.
// PARAMETERS
//  DEPTH_WORDS  32  number of 32-bit words in the array; address range 0 .. 4*DEPTH_WORDS-1
//  LATENCY      4   cycles from request acceptance to ack_o; legal range 1..15
// PORTS
//  clk_i    in   1   clock; one clock domain, all logic on rising edge
//  rst_n_i  in   1   asynchronous, active-low reset
//  req_i    in   1   MEM-stage access request (MemRead|MemWrite); held high while stall_o is high
//  we_i     in   1   1 = store, 0 = load; sampled with req_i
//  addr_i   in   32  byte address (ALU result); sampled with req_i
//  wdata_i  in   32  store data; sampled with req_i
//  stall_o  out  1   freeze PC, IF/ID, ID/EX, EX/MEM while the access is outstanding
//  ack_o    out  1   one-cycle pulse: access complete; rdata_o/err_o valid
//  rdata_o  out  32  load data, held until next ack_o
//  err_o    out  1   misaligned (addr_i[1:0]!=0) or out-of-range access; valid with ack_o
// BEHAVIOUR
//  Reset (async, rst_n_i=0)
//   - State goes to IDLE; ack_o=0, rdata_o=0, err_o=0, latched request cleared.
//   - Array contents are not reset.
//   - Reset mid-access abandons the access; no write is committed.
//  FSM states: IDLE, BUSY, ACK.
//   - IDLE: req_i=1 latches we/addr/wdata.
//     - Legal access: go to BUSY with cnt=LATENCY-1.
//     - LATENCY=1 or illegal access: go straight to ACK.
//   - BUSY: cnt decrements each cycle; at cnt==1 go to ACK. req_i/addr_i changes are ignored.
//   - ACK: ack_o=1 for exactly one cycle, then go to IDLE.
//     - req_i seen in the ACK cycle is the same instruction and is NOT re-accepted.
//  Latency: request sampled at edge T -> ack_o high in the cycle after edge T+LATENCY-1,
//   i.e. exactly LATENCY cycles after acceptance.
//  stall_o (combinational) = (IDLE & req_i) | BUSY; it is 0 in the ACK cycle, so the
//   pipeline advances on the edge that ends ACK.
//  Store: the array is written on the clock edge that enters ACK, only when err is clear.
//   rdata_o is unchanged on a store.
//  Load: rdata_o <= mem[addr[log2(4*DEPTH_WORDS)-1:2]], registered on entry to ACK.
//   - Error: rdata_o <= 0, err_o=1, array untouched.
//  err_o is registered with rdata_o and cleared on the next accepted request.
//  Back-to-back: earliest next acceptance is the IDLE cycle after ACK.
//   A request present in that cycle raises stall_o immediately.
//  Error precedence: misalignment and out-of-range are both reported as err_o.
//   The array never sees illegal accesses.
// STRUCTURE
//  Shared package mem_pkg: state encoding (IDLE/BUSY/ACK), WORD_W=32, BYTE_OFF_W=2,
//   function word_index(addr).
//  Sub-module dmem_array: DEPTH_WORDS x 32 register array, synchronous write,
//   combinational read.
//  dmem_responder holds the FSM, latency counter, request latch and output registers.
// TESTING
//  1 Reset: hold rst_n_i=0 three cycles with req_i=1 -> ack_o=0, rdata_o=0, err_o=0, stall_o=0.
//  2 Store then load, LATENCY=4:
//   - req_i=1, we_i=1, addr=0x10, wdata=0xDEADBEEF -> stall_o high 4 cycles, ack_o pulse in cycle 5.
//   - Then load 0x10 -> rdata_o=0xDEADBEEF, err_o=0.
//  3 LATENCY=1: load addr 0x0 after writing 0x5 -> stall_o high 1 cycle, ack_o next cycle,
//   rdata_o=0x5.
//  4 Misaligned store, addr=0x13 -> ack_o with err_o=1; a following load of 0x10
//   returns the unchanged old word.
//  5 Out of range, addr=0x80 (DEPTH_WORDS=32) -> err_o=1, rdata_o=0, array unchanged.
//  6 Reset mid-access: assert rst_n_i in BUSY of store 0x20=0x1234 -> no ack_o;
//   a later load of 0x20 returns the prior value. Also check req_i held through ACK
//   is not re-accepted.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and address helpers for the data-memory responder
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_OFF_W = 2;
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  function automatic logic [WORD_W-BYTE_OFF_W-1:0] word_index(input logic [WORD_W-1:0] addr);
    return addr[WORD_W-1:BYTE_OFF_W];
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-wide register array, synchronous write, combinational read
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_idx] <= i_wdata;
  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory that stalls the pipeline, then acks
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_we;
  logic [WORD_W-1:0] r_addr, r_wdata;
  logic w_idle, w_accept, w_src_we, w_bad, w_enter_ack, w_wr;
  logic [WORD_W-1:0] w_src_addr, w_src_wdata, w_rdata;
  logic [WORD_W-BYTE_OFF_W-1:0] w_word;
  logic [AW-1:0] w_idx;
  assign w_idle = r_state == IDLE;
  assign w_accept = w_idle & req_i;
  // in IDLE the live inputs drive the array so a one-cycle access needs no latch
  assign w_src_we = w_idle ? we_i : r_we;
  assign w_src_addr = w_idle ? addr_i : r_addr;
  assign w_src_wdata = w_idle ? wdata_i : r_wdata;
  assign w_word = word_index(w_src_addr);
  assign w_idx = w_word[AW-1:0];
  assign w_bad = (w_src_addr[BYTE_OFF_W-1:0] != '0) | (w_word >= (WORD_W-BYTE_OFF_W)'(DEPTH_WORDS));
  assign w_enter_ack = (w_next == ACK) & (r_state != ACK);
  assign w_wr = w_enter_ack & w_src_we & ~w_bad;
  assign stall_o = rst_n_i & (w_accept | (r_state == BUSY));
  assign ack_o = r_state == ACK;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = (LATENCY == 1 || w_bad) ? ACK : BUSY;
    else if (r_state == BUSY && r_cnt == 4'd1) w_next = ACK;
    else if (r_state == ACK) w_next = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_cnt <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      rdata_o <= '0;
      err_o <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we <= we_i;
        r_addr <= addr_i;
        r_wdata <= wdata_i;
        r_cnt <= 4'(LATENCY - 1);
        err_o <= 1'b0;
      end else if (r_state == BUSY) r_cnt <= r_cnt - 4'd1;
      if (w_enter_ack) begin
        err_o <= w_bad;
        if (!w_src_we) rdata_o <= w_bad ? '0 : w_rdata;
      end
    end
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .i_clk(clk_i),
    .i_we(w_wr),
    .i_idx(w_idx),
    .i_wdata(w_src_wdata),
    .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responders (latency 4 and 1)
module tb_dmem_responder;
  typedef struct packed {
    logic [7:0]  stalls;
    logic [7:0]  ack_at;
    logic [31:0] rd;
    logic        e;
    logic        e2;
    logic        sia;
    logic        post;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req [2], we [2], stall [2], ack [2], err [2];
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic [31:0] mdl [2][32];
  logic [31:0] last_rd [2];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(4)) u_lat4 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .stall_o(stall[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0])
  );
  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .stall_o(stall[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1])
  );
  function automatic int lat(input int s);
    return s == 0 ? 4 : 1;
  endfunction
  // expected behaviour of one access: legal words take LATENCY cycles, errors ack immediately
  function automatic obs_t model_op(input int s, input logic w, input logic [31:0] a, input logic [31:0] d);
    obs_t o;
    logic legal;
    legal = (a[1:0] == 2'b00) && (a < 32'd128);
    o = '0;
    o.stalls = 8'(legal ? lat(s) : 1);
    o.ack_at = o.stalls + 8'd1;
    o.e = !legal;
    o.e2 = (legal && lat(s) > 1) ? 1'b0 : !legal;
    if (w) begin
      if (legal) mdl[s][a[6:2]] = d;
    end else last_rd[s] = legal ? mdl[s][a[6:2]] : 32'd0;
    o.rd = last_rd[s];
    return o;
  endfunction
  function automatic string fmt(input obs_t o);
    return $sformatf("stalls=%0d ack_at=%0d rdata=%h err=%b err_c2=%b stall_in_ack=%b reaccept=%b",
                     o.stalls, o.ack_at, o.rd, o.e, o.e2, o.sia, o.post);
  endfunction
  task automatic access(input int s, input logic w, input logic [31:0] a, input logic [31:0] d, output obs_t o);
    o = '0;
    o.ack_at = 8'hFF;
    o.rd = 'x;
    @(negedge clk);
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
    #1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) o.e2 = err[s];
      if (ack[s]) begin
        o.ack_at = 8'(c); o.rd = rdata[s]; o.e = err[s]; o.sia = stall[s];
        break;
      end
      if (stall[s]) o.stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req[s] = 1'b0; we[s] = 1'b0;
    #1;
    o.post = stall[s] | ack[s];
  endtask
  task automatic run_op(input string name, input int s, input logic w, input logic [31:0] a, input logic [31:0] d);
    obs_t o, x;
    x = model_op(s, w, a, d);
    access(s, w, a, d, o);
    n_chk++;
    if (o !== x) begin
      n_fail++;
      $display("FAIL %s (lat%0d %s @%h): got %s ; want %s", name, lat(s), w ? "st" : "ld", a, fmt(o), fmt(x));
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req[0] = 1'b1; req[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_chk++;
      if ({ack[s], stall[s], err[s], rdata[s]} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset lat%0d: ack=%b stall=%b err=%b rdata=%h, want all 0", lat(s), ack[s], stall[s], err[s], rdata[s]);
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    last_rd[0] = 0; last_rd[1] = 0;
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic test_store_load();
    run_op("store_deadbeef", 0, 1'b1, 32'h10, 32'hDEADBEEF);
    run_op("load_deadbeef", 0, 1'b0, 32'h10, 32'h0);
    run_op("store_top_word", 0, 1'b1, 32'h7C, $urandom);
    run_op("load_top_word", 0, 1'b0, 32'h7C, 32'h0);
  endtask
  task automatic test_lat1();
    run_op("lat1_store5", 1, 1'b1, 32'h0, 32'h5);
    run_op("lat1_load5", 1, 1'b0, 32'h0, 32'h0);
    run_op("lat1_misaligned_load", 1, 1'b0, 32'h2, 32'h0);
  endtask
  task automatic test_misaligned();
    run_op("misaligned_store", 0, 1'b1, 32'h13, 32'hCAFEF00D);
    run_op("load_after_misaligned", 0, 1'b0, 32'h10, 32'h0);
  endtask
  task automatic test_out_of_range();
    run_op("seed_word0", 0, 1'b1, 32'h0, 32'h11111111);
    run_op("oor_load", 0, 1'b0, 32'h80, 32'h0);
    run_op("oor_store", 0, 1'b1, 32'h80, 32'h22222222);
    run_op("oor_store_high", 0, 1'b1, 32'hFFFFFFFC, 32'h33333333);
    run_op("word0_unchanged", 0, 1'b0, 32'h0, 32'h0);
  endtask
  task automatic test_reset_mid();
    int acks;
    run_op("prior_0x20", 0, 1'b1, 32'h20, 32'hAAAA5555);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++;
    if (stall[0] !== 1'b1 || ack[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_before_reset: stall=%b ack=%b, want stall=1 ack=0", stall[0], ack[0]);
    end
    #2 rst_n = 1'b0;
    #1 req[0] = 1'b0; we[0] = 1'b0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acks += int'(ack[0]);
    end
    n_chk++;
    if (acks != 0 || rdata[0] !== 32'd0 || err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_access: acks=%0d rdata=%h err=%b, want 0/0/0", acks, rdata[0], err[0]);
    end
    last_rd[0] = 0; last_rd[1] = 0;
    rst_n = 1'b1;
    run_op("load_after_abandoned_store", 0, 1'b0, 32'h20, 32'h0);
  endtask
  task automatic test_random();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 32; i++) run_op("prefill", s, 1'b1, 32'(i * 4), $urandom);
    for (int i = 0; i < 60; i++) begin
      int s, k;
      logic [31:0] a;
      s = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 7));
      a = (k < 6) ? 32'($urandom_range(0, 31) * 4) : (k == 6) ? (32'($urandom_range(0, 31) * 4) | 32'($urandom_range(1, 3))) : ($urandom | 32'h80);
      run_op("random", s, 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0; last_rd[s] = '0;
    end
    test_reset();
    test_store_load();
    test_lat1();
    test_misaligned();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
